// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state type, parity-mode codes and the
// divide-counter width helper used by the transmitter (and the future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Width of a counter spanning 0..div-1; never narrower than one bit.
    function automatic int baud_cnt_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: tick is high on the last cycle of every BAUD_DIV-cycle
// bit period; restart holds the count at the start of a period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int               CNT_W = baud_cnt_w(BAUD_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: LSB-first frames with optional parity and
// one or two stop bits. Parity support is built only with UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 4,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    uart_tx_state_t    state;
    uart_tx_state_t    state_next;
    logic [DATA_W-1:0] data_q;
    logic              two_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_next;
    logic              stop_cnt;
    logic              stop_cnt_next;
    logic              tick;
    logic              restart;
    logic              accept;
    logic              tx_next;
    logic              done_next;

`ifdef UART_TX_PARITY_EN
    logic [1:0] par_q;
    logic       par_en;
    logic       parity_bit;

    assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign parity_bit = (^data_q) ^ (par_q == PAR_ODD);
`else
    logic unused_parity_mode;

    assign unused_parity_mode = ^parity_mode;
`endif

    assign accept  = in_valid && in_ready;
    assign restart = (state == IDLE);

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = par_en ? PARITY : STOP;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt || !two_q) begin
                        state_next    = IDLE;
                        stop_cnt_next = 1'b0;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx is registered from the level of the bit that starts on the next edge.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        done_next = (state == STOP) && (state_next == IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_q[bit_cnt_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            data_q   <= '0;
            two_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= PAR_NONE;
`endif
        end else begin
            tx       <= tx_next;
            tx_done  <= done_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            if (accept) begin
                data_q <= in_data;
                two_q  <= two_stop;
`ifdef UART_TX_PARITY_EN
                par_q  <= parity_mode;
`endif
            end
        end
    end

endmodule
